// File: rtl/times_table_loader_pkg.sv
// Shared constants and state types for the times-table loader.
// Default geometry: 3-bit operands, 64-entry x 6-bit table.
package times_table_pkg;

    localparam int OP_W   = 3;
    localparam int ADDR_W = 2 * OP_W;
    localparam int DATA_W = 2 * OP_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_WR,
        S_RDREQ,
        S_CMP,
        S_DONE
    } state_t;

    typedef enum logic {
        PH_WRITE,
        PH_VERIFY
    } phase_t;

endpackage

// File: rtl/times_table_loader_if.sv
// BRAM port-A bus between the loader (master) and the memory (slave).
// mem_dout is the registered read data returned by the memory.
interface times_table_loader_if
    import times_table_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );

endinterface

// File: rtl/times_table_loader_seq_mult.sv
// Iterative shift-add multiplier: one partial product per step.
// clear zeroes the accumulator and bit index; a/b must be stable while stepping.
module seq_mult
    import times_table_pkg::*;
#(
    parameter int OP_W = times_table_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [2*OP_W-1:0] product
);

    logic [OP_W-1:0]   k;
    logic [OP_W-1:0]   b_sh;
    logic [2*OP_W-1:0] a_ext;
    logic [2*OP_W-1:0] term;

    assign a_ext = {{OP_W{1'b0}}, a};
    assign b_sh  = b >> k;
    assign term  = b_sh[0] ? (a_ext << k) : '0;

    // Accumulate the partial product selected by bit k of b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            k       <= '0;
        end else if (clear) begin
            product <= '0;
            k       <= '0;
        end else if (step) begin
            product <= product + term;
            k       <= k + 1'b1;
        end
    end

endmodule

// File: rtl/times_table_loader.sv
// Fills the 64-entry times table through BRAM port A, then reads it
// back and records the first mismatching address.
module times_table_loader #(
    parameter int OP_W = times_table_pkg::OP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [2*OP_W-1:0]    err_addr,
    times_table_loader_if.master mem
);

    import times_table_pkg::*;

    localparam int AW = 2 * OP_W;
    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    state_t          state;
    phase_t          phase;
    logic [AW-1:0]   addr;
    logic [OP_W-1:0] kcnt;
    logic [AW-1:0]   product;
    logic            clear;
    logic            step;
    logic            k_last;
    logic            a_last;

    assign k_last = (int'(kcnt) == OP_W - 1);
    assign a_last = (addr == LAST);
    assign step   = (state == S_MUL);
    assign clear  = (state == S_IDLE && start)
                  || (state == S_WR)
                  || (state == S_CMP && !a_last);

    seq_mult #(
        .OP_W    (OP_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .step    (step),
        .a       (addr[AW-1:OP_W]),
        .b       (addr[OP_W-1:0]),
        .product (product)
    );

    // Sequencer: multiply, then write (WRITE phase) or read and compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            phase    <= PH_WRITE;
            addr     <= '0;
            kcnt     <= '0;
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_MUL;
                        phase    <= PH_WRITE;
                        addr     <= '0;
                        kcnt     <= '0;
                        error    <= 1'b0;
                        err_addr <= '0;
                    end
                end
                S_MUL: begin
                    if (k_last) begin
                        kcnt  <= '0;
                        state <= (phase == PH_WRITE) ? S_WR : S_RDREQ;
                    end else begin
                        kcnt <= kcnt + 1'b1;
                    end
                end
                S_WR: begin
                    state <= S_MUL;
                    if (a_last) begin
                        addr  <= '0;
                        phase <= PH_VERIFY;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                S_RDREQ: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (mem.mem_dout != product && !error) begin
                        error    <= 1'b1;
                        err_addr <= addr;
                    end
                    if (a_last) begin
                        state <= S_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= S_MUL;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done         = (state == S_DONE);
    assign mem.mem_en   = (state == S_WR) || (state == S_RDREQ);
    assign mem.mem_we   = (state == S_WR);
    assign mem.mem_addr = addr;
    assign mem.mem_din  = product;

endmodule

// File: tb/tb_times_table_loader.sv
// Bench for times_table_loader: 1-cycle BRAM model with fault injection
// and a cycle-indexed reference of the load/verify schedule.
module tb_times_table_loader;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       error;
    logic [5:0] err_addr;

    times_table_loader_if bus ();

    times_table_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_addr (err_addr),
        .mem      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [5:0]  mem [64];
    logic [63:0] fault = '0;
    int          wcount = 0;

    // Behavioural BRAM: synchronous write, 1-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_din;
                wcount <= wcount + 1;
            end else begin
                bus.mem_dout <= fault[bus.mem_addr] ? 6'd0
                                                    : mem[bus.mem_addr];
            end
        end
    end

    function automatic int prod(input int e);
        return (e / 8) * (e % 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference: c is the cycle index since the start-sampling edge.
    logic       run       = 1'b0;
    int         c         = 0;
    logic [5:0] idle_addr = '0;
    logic       din_zero  = 1'b1;
    logic       m_err     = 1'b0;
    logic [5:0] m_erra    = '0;

    // Model advances one schedule cycle per edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run       <= 1'b0;
            c         <= 0;
            idle_addr <= '0;
            din_zero  <= 1'b1;
            m_err     <= 1'b0;
            m_erra    <= '0;
        end else if (run) begin
            if (c == 577) begin
                run       <= 1'b0;
                idle_addr <= 6'd63;
            end else begin
                if (c >= 257 && (c - 257) % 5 == 4 && !m_err
                    && fault[(c - 257) / 5]
                    && prod((c - 257) / 5) != 0) begin
                    m_err  <= 1'b1;
                    m_erra <= 6'((c - 257) / 5);
                end
                c <= c + 1;
            end
        end else if (start) begin
            run      <= 1'b1;
            c        <= 1;
            din_zero <= 1'b0;
            m_err    <= 1'b0;
            m_erra   <= '0;
        end
    end

    // Compare all outputs against the reference every cycle.
    always @(negedge clk) begin
        int         e;
        int         r;
        logic       xb;
        logic       xd;
        logic       xen;
        logic       xwe;
        logic       cd;
        logic [5:0] xa;
        logic [5:0] xdin;
        xb   = 1'b0;
        xd   = 1'b0;
        xen  = 1'b0;
        xwe  = 1'b0;
        cd   = 1'b0;
        xa   = idle_addr;
        xdin = '0;
        if (run) begin
            if (c <= 256) begin
                e    = (c - 1) / 4;
                r    = (c - 1) % 4;
                xb   = 1'b1;
                xa   = 6'(e);
                xen  = (r == 3);
                xwe  = (r == 3);
                cd   = (r == 3);
                xdin = 6'(prod(e));
            end else if (c <= 576) begin
                e   = (c - 257) / 5;
                r   = (c - 257) % 5;
                xb  = 1'b1;
                xa  = 6'(e);
                xen = (r == 3);
            end else begin
                xd = 1'b1;
                xa = 6'd63;
            end
        end else begin
            cd = din_zero;
        end
        chk("busy", 32'(busy), 32'(xb));
        chk("done", 32'(done), 32'(xd));
        chk("mem_en", 32'(bus.mem_en), 32'(xen));
        chk("mem_we", 32'(bus.mem_we), 32'(xwe));
        chk("mem_addr", 32'(bus.mem_addr), 32'(xa));
        chk("error", 32'(error), 32'(m_err));
        chk("err_addr", 32'(err_addr), 32'(m_erra));
        if (cd) chk("mem_din", 32'(bus.mem_din), 32'(xdin));
    end

    task automatic chk_reset_outs();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_addr", 32'(err_addr), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_din", 32'(bus.mem_din), 0);
    endtask

    // One run; pulse_at re-pulses start, abort_at asserts reset mid-run.
    task automatic do_run(input int pulse_at, input int abort_at,
                          output int dcyc);
        int n;
        dcyc = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 1000) begin
            if (abort_at != 0 && n + 1 == abort_at) begin
                #2 rst = 1'b1;
                #1 chk_reset_outs();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            start = (n + 1 == pulse_at);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        if (done) dcyc = n + 1;
        else chk("done_timeout", 32'(n), 577);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int w0;
        int nf;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        w0 = wcount;
        do_run(0, 0, d);
        chk("clean_done_cycle", 32'(d), 577);
        chk("clean_error", 32'(error), 0);
        chk("clean_writes", 32'(wcount - w0), 64);
        chk("mem63", 32'(mem[63]), 49);
        chk("mem_5x3", 32'(mem[43]), 15);
        chk("mem_0x7", 32'(mem[7]), 0);

        fault = '0;
        fault[21] = 1'b1;
        do_run(0, 0, d);
        chk("f21_error", 32'(error), 1);
        chk("f21_err_addr", 32'(err_addr), 21);

        fault[50] = 1'b1;
        do_run(0, 0, d);
        chk("f21_50_error", 32'(error), 1);
        chk("f21_50_err_addr", 32'(err_addr), 21);

        fault = '0;
        do_run(100, 0, d);
        chk("pulse_done_cycle", 32'(d), 577);
        chk("after_fault_error", 32'(error), 0);
        chk("after_fault_err_addr", 32'(err_addr), 0);

        do_run(0, 150, d);
        do_run(0, 0, d);
        chk("post_rst_done_cycle", 32'(d), 577);
        chk("post_rst_error", 32'(error), 0);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            fault = '0;
            nf = $urandom_range(0, 3);
            for (int j = 0; j < nf; j++) fault[$urandom_range(0, 63)] = 1'b1;
            if (i % 3 == 2) begin
                do_run($urandom_range(2, 576), $urandom_range(2, 576), d);
            end else begin
                do_run($urandom_range(2, 576), 0, d);
                chk("rand_done_cycle", 32'(d), 577);
            end
        end

        fault = '0;
        @(negedge clk);
        start = 1'b1;
        nf = 0;
        while (!done && nf < 1000) begin
            @(negedge clk);
            nf++;
        end
        chk("held_first_done", 32'(done), 1);
        repeat (20) @(negedge clk);
        chk("held_restart_busy", 32'(busy), 1);
        start = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_outs();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
